// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the byte-serialising memory controller.
//   state_e : controller FSM states
//   BYTE_W  : width of the RAM data port
package mem_ctrl_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/mem_ctrl_if.sv
// Requester-side bus of mem_ctrl: N flattened request channels plus the
// per-channel completion pulse and the shared read-data return.
//   master : requester view (drives req/we/addr/wdata/len)
//   slave  : controller view (drives done/rdata)
interface mem_ctrl_if #(
  parameter int unsigned NCH    = 2,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LEN_W  = 2
);

  logic [NCH-1:0]        req;
  logic [NCH-1:0]        we;
  logic [NCH*ADDR_W-1:0] addr;
  logic [NCH*DATA_W-1:0] wdata;
  logic [NCH*LEN_W-1:0]  len;
  logic [NCH-1:0]        done;
  logic [DATA_W-1:0]     rdata;

  modport master (
    output req, we, addr, wdata, len,
    input  done, rdata
  );

  modport slave (
    input  req, we, addr, wdata, len,
    output done, rdata
  );

endinterface

// File: rtl/mem_ctrl_arb.sv
// Combinational requester arbiter.
//   req_i  : per-channel request
//   last_i : index of the previous grant (round-robin pointer)
//   gnt_o  : one-hot grant, all zero when nothing requests
//   idx_o  : index of the granted channel
// RR=0 : highest requesting index wins. RR=1 : search starts at last_i+1.
module rr_arbiter #(
  parameter int unsigned NCH   = 2,
  parameter int unsigned RR    = 0,
  parameter int unsigned IDX_W = 1
) (
  input  logic [NCH-1:0]   req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic [NCH-1:0]   gnt_o,
  output logic [IDX_W-1:0] idx_o
);

  always_comb begin
    logic        found;
    int unsigned c;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    c     = 0;
    if (RR == 0) begin
      // Later (higher) indices overwrite earlier ones.
      for (int unsigned i = 0; i < NCH; i++) begin
        if (req_i[i]) idx_o = IDX_W'(i);
      end
    end else begin
      for (int unsigned off = 1; off <= NCH; off++) begin
        c = (32'(last_i) + off) % NCH;
        if (!found && req_i[c]) begin
          found = 1'b1;
          idx_o = IDX_W'(c);
        end
      end
    end
    if (|req_i) gnt_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/mem_ctrl.sv
// Memory controller: arbitrates N requesters onto one byte-wide RAM port,
// serialises 1..DATA_W/8-byte little-endian transfers and assembles reads.
//   clk, rst_n : clock, asynchronous active-low reset
//   rdy        : system ready, low freezes the controller
//   cpu        : requester bus (req/we/addr/wdata/len in, done/rdata out)
//   mem_a      : RAM byte address
//   mem_we     : RAM write strobe
//   mem_dout   : RAM write byte
//   mem_din    : RAM read byte, valid one cycle after its address
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned NCH    = 2,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RR     = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rdy,
  mem_ctrl_if.slave         cpu,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_we,
  output logic [BYTE_W-1:0] mem_dout,
  input  logic [BYTE_W-1:0] mem_din
);

  localparam int unsigned NB    = DATA_W / BYTE_W;
  localparam int unsigned LEN_W = (NB > 1) ? $clog2(NB) : 1;
  localparam int unsigned IDX_W = (NCH > 1) ? $clog2(NCH) : 1;

  state_e             state_q;
  logic [IDX_W-1:0]   g_q;
  logic [IDX_W-1:0]   last_grant_q;
  logic               we_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   k_q;
  logic [LEN_W-1:0]   kprev_q;
  logic               rd_issue_q;
  logic [ADDR_W-1:0]  mem_a_q;
  logic [DATA_W-1:0]  wsh_q;
  logic [DATA_W-1:0]  rdata_q;

  logic [NCH-1:0]     gnt;
  logic [IDX_W-1:0]   gidx;
  logic               issue;
  logic               last_byte;
  logic [NCH-1:0]     done_c;

  rr_arbiter #(
    .NCH  (NCH),
    .RR   (RR),
    .IDX_W(IDX_W)
  ) u_arb (
    .req_i (cpu.req),
    .last_i(last_grant_q),
    .gnt_o (gnt),
    .idx_o (gidx)
  );

  assign issue     = (state_q == XFER) && rdy;
  assign last_byte = (k_q == len_q);

  // Controller FSM with transfer datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      g_q          <= '0;
      last_grant_q <= IDX_W'(NCH - 1);
      we_q         <= 1'b0;
      len_q        <= '0;
      k_q          <= '0;
      kprev_q      <= '0;
      rd_issue_q   <= 1'b0;
      mem_a_q      <= '0;
      wsh_q        <= '0;
      rdata_q      <= '0;
    end else begin
      // Read capture trails the issue by one cycle and ignores rdy, so the
      // byte addressed just before a stall is still collected.
      rd_issue_q <= issue && !we_q;
      kprev_q    <= k_q;
      if (rd_issue_q) rdata_q[BYTE_W*kprev_q +: BYTE_W] <= mem_din;

      case (state_q)
        IDLE: begin
          if ((|gnt) && rdy) begin
            g_q          <= gidx;
            last_grant_q <= gidx;
            we_q         <= cpu.we[gidx];
            len_q        <= cpu.len[gidx*LEN_W +: LEN_W];
            mem_a_q      <= cpu.addr[gidx*ADDR_W +: ADDR_W];
            wsh_q        <= cpu.wdata[gidx*DATA_W +: DATA_W];
            k_q          <= '0;
            rdata_q      <= '0;
            state_q      <= XFER;
          end
        end
        XFER: begin
          if (rdy) begin
            if (last_byte) begin
              state_q <= we_q ? DONE : WAIT;
            end else begin
              k_q     <= k_q + LEN_W'(1);
              mem_a_q <= mem_a_q + ADDR_W'(1);
              wsh_q   <= wsh_q >> BYTE_W;
            end
          end
        end
        // The last capture fires on the first WAIT cycle regardless of rdy.
        WAIT: if (rdy) state_q <= DONE;
        DONE: if (rdy) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Completion pulse for the granted channel, suppressed while stalled.
  always_comb begin
    done_c = '0;
    if ((state_q == DONE) && rdy) done_c[g_q] = 1'b1;
  end

  assign cpu.done  = done_c;
  assign cpu.rdata = rdata_q;
  assign mem_a     = mem_a_q;
  assign mem_dout  = wsh_q[BYTE_W-1:0];
  // Strobe is qualified by rdy in-cycle so a stalled cycle never writes.
  assign mem_we    = (state_q == XFER) && we_q && rdy;

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: two instances (fixed priority, round-robin)
// sharing clk/rst_n/rdy, each with a 4 KiB byte RAM (low 12 address bits).
module tb_mem_ctrl;

  localparam int unsigned NCH    = 2;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned LEN_W  = 2;

  typedef struct {
    int          d;
    int          ch;
    bit          chk;
    logic [31:0] rdata;
    int          cyc;
  } exp_done_t;

  typedef struct {
    int          d;
    logic [31:0] a;
    logic [7:0]  v;
    int          cyc;
  } exp_wr_t;

  logic clk;
  logic rst_n;
  logic rdy;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  logic [NCH-1:0]    req_v   [2];
  logic [NCH-1:0]    we_v    [2];
  logic [ADDR_W-1:0] addr_v  [2][NCH];
  logic [DATA_W-1:0] wdata_v [2][NCH];
  logic [LEN_W-1:0]  len_v   [2][NCH];
  logic [NCH-1:0]    done_v  [2];
  logic [DATA_W-1:0] rdata_v [2];
  logic [ADDR_W-1:0] mem_a_v [2];
  logic              mem_we_v[2];
  logic [7:0]        mem_dout_v[2];
  logic [7:0]        mem_din_v [2];
  logic [7:0]        ram [2][4096];

  exp_done_t exp_done_q[$];
  exp_wr_t   exp_wr_q[$];
  exp_done_t ed;
  exp_wr_t   ew;

  for (genvar d = 0; d < 2; d++) begin : g_dut
    mem_ctrl_if #(.NCH(NCH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) cpu ();
    assign cpu.req   = req_v[d];
    assign cpu.we    = we_v[d];
    assign cpu.addr  = {addr_v[d][1], addr_v[d][0]};
    assign cpu.wdata = {wdata_v[d][1], wdata_v[d][0]};
    assign cpu.len   = {len_v[d][1], len_v[d][0]};
    assign done_v[d]  = cpu.done;
    assign rdata_v[d] = cpu.rdata;

    mem_ctrl #(.NCH(NCH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RR(d)) u_dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .rdy     (rdy),
      .cpu     (cpu),
      .mem_a   (mem_a_v[d]),
      .mem_we  (mem_we_v[d]),
      .mem_dout(mem_dout_v[d]),
      .mem_din (mem_din_v[d])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Byte RAM models, registered read (data one cycle after address).
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (mem_we_v[d] === 1'b1) ram[d][mem_a_v[d][11:0]] <= mem_dout_v[d];
      mem_din_v[d] <= ram[d][mem_a_v[d][11:0]];
    end
  end

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void push_wr(input int d, input logic [31:0] a,
                                  input logic [7:0] v, input int c);
    exp_wr_t e;
    e.d = d; e.a = a; e.v = v; e.cyc = c;
    exp_wr_q.push_back(e);
  endfunction

  function automatic void push_done(input int d, input int ch, input bit chk,
                                    input logic [31:0] rd, input int c);
    exp_done_t e;
    e.d = d; e.ch = ch; e.chk = chk; e.rdata = rd; e.cyc = c;
    exp_done_q.push_back(e);
  endfunction

  // Monitor: every RAM write and every done pulse pops the scoreboard.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (mem_we_v[d] !== 1'b0) begin
        if (exp_wr_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_write dut%0d: got addr %0h data %0h, expected none (cycle %0d)",
                   d, mem_a_v[d], mem_dout_v[d], cyc);
        end else begin
          ew = exp_wr_q.pop_front();
          check("wr_dut",   64'(d),             64'(ew.d));
          check("wr_addr",  64'(mem_a_v[d]),    64'(ew.a));
          check("wr_data",  64'(mem_dout_v[d]), 64'(ew.v));
          check("wr_cycle", 64'(cyc),           64'(ew.cyc));
        end
      end
      if (done_v[d] !== '0) begin
        if (exp_done_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_done dut%0d: got done %0b, expected none (cycle %0d)",
                   d, done_v[d], cyc);
        end else begin
          logic [NCH-1:0] ev;
          ed = exp_done_q.pop_front();
          ev = '0;
          ev[ed.ch] = 1'b1;
          check("done_dut",   64'(d),         64'(ed.d));
          check("done_vec",   64'(done_v[d]), 64'(ev));
          check("done_cycle", 64'(cyc),       64'(ed.cyc));
          if (ed.chk) check("rdata", 64'(rdata_v[d]), 64'(ed.rdata));
        end
      end
    end
  end

  // One requester transaction: raise req, wait (bounded) for done, drop req.
  task automatic do_txn(input int d, input int ch, input logic w,
                        input logic [31:0] a, input logic [1:0] l,
                        input logic [31:0] wd);
    bit seen;
    we_v[d][ch]    = w;
    addr_v[d][ch]  = a;
    len_v[d][ch]   = l;
    wdata_v[d][ch] = wd;
    req_v[d][ch]   = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(negedge clk);
      if (done_v[d][ch] === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      n_cmp++;
      n_err++;
      $display("FAIL timeout dut%0d ch%0d: got no done, expected done within 200 cycles", d, ch);
    end
    @(posedge clk);
    #1;
    req_v[d][ch] = 1'b0;
  endtask

  task automatic next_cycle(output int t0);
    @(posedge clk);
    #1;
    t0 = cyc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    rst_n = 1'b0;
    rdy   = 1'b1;
    for (int d = 0; d < 2; d++) begin
      req_v[d] = '0;
      we_v[d]  = '0;
      for (int c = 0; c < NCH; c++) begin
        addr_v[d][c]  = '0;
        wdata_v[d][c] = '0;
        len_v[d][c]   = '0;
      end
      for (int i = 0; i < 4096; i++) ram[d][i] = 8'h00;
    end
    ram[0][12'h200] = 8'h34; ram[0][12'h201] = 8'h12;
    ram[0][12'hFFE] = 8'h01; ram[0][12'hFFF] = 8'h02;
    ram[0][12'h000] = 8'h03; ram[0][12'h001] = 8'h04;
    ram[0][12'h500] = 8'h5A; ram[0][12'h501] = 8'h6B;
    ram[0][12'h502] = 8'h7C; ram[0][12'h503] = 8'h8D;

    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("rst_done",     64'(done_v[d]),     64'(0));
      check("rst_rdata",    64'(rdata_v[d]),    64'(0));
      check("rst_mem_a",    64'(mem_a_v[d]),    64'(0));
      check("rst_mem_we",   64'(mem_we_v[d]),   64'(0));
      check("rst_mem_dout", 64'(mem_dout_v[d]), 64'(0));
    end
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Single 4-byte write on ch0.
    next_cycle(t0);
    push_wr(0, 32'h100, 8'hAA, t0 + 1);
    push_wr(0, 32'h101, 8'hBB, t0 + 2);
    push_wr(0, 32'h102, 8'hCC, t0 + 3);
    push_wr(0, 32'h103, 8'hDD, t0 + 4);
    push_done(0, 0, 1'b0, 32'h0, t0 + 5);
    do_txn(0, 0, 1'b1, 32'h100, 2'd3, 32'hDDCCBBAA);

    // 4-byte read wrapping across the top of the address space.
    next_cycle(t0);
    push_done(0, 1, 1'b1, 32'h04030201, t0 + 6);
    do_txn(0, 1, 1'b0, 32'hFFFFFFFE, 2'd3, 32'h0);

    // 2-byte read: upper lanes must come back zero.
    next_cycle(t0);
    push_done(0, 1, 1'b1, 32'h00001234, t0 + 4);
    do_txn(0, 1, 1'b0, 32'h200, 2'd1, 32'h0);

    // Fixed-priority contention: ch1 first, ch0 after the IDLE bubble.
    next_cycle(t0);
    push_wr(0, 32'h400, 8'hEF, t0 + 1);
    push_wr(0, 32'h401, 8'hBE, t0 + 2);
    push_done(0, 1, 1'b0, 32'h0, t0 + 3);
    push_done(0, 0, 1'b1, 32'h00000034, t0 + 7);
    fork
      do_txn(0, 1, 1'b1, 32'h400, 2'd1, 32'h0000BEEF);
      do_txn(0, 0, 1'b0, 32'h200, 2'd0, 32'h0);
    join

    // 4-byte read with a 3-cycle rdy stall after byte 1.
    next_cycle(t0);
    push_done(0, 0, 1'b1, 32'h8D7C6B5A, t0 + 9);
    fork
      do_txn(0, 0, 1'b0, 32'h500, 2'd3, 32'h0);
      begin
        repeat (3) @(posedge clk);
        #1 rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1 rdy = 1'b1;
      end
    join

    // Round-robin contention on the RR instance: grants 0,1,0,1.
    next_cycle(t0);
    push_wr(1, 32'h300, 8'h11, t0 + 1);
    push_done(1, 0, 1'b0, 32'h0, t0 + 2);
    push_wr(1, 32'h310, 8'h22, t0 + 4);
    push_done(1, 1, 1'b0, 32'h0, t0 + 5);
    push_wr(1, 32'h301, 8'h33, t0 + 7);
    push_done(1, 0, 1'b0, 32'h0, t0 + 8);
    push_wr(1, 32'h311, 8'h44, t0 + 10);
    push_done(1, 1, 1'b0, 32'h0, t0 + 11);
    fork
      begin
        do_txn(1, 0, 1'b1, 32'h300, 2'd0, 32'h11);
        do_txn(1, 0, 1'b1, 32'h301, 2'd0, 32'h33);
      end
      begin
        do_txn(1, 1, 1'b1, 32'h310, 2'd0, 32'h22);
        do_txn(1, 1, 1'b1, 32'h311, 2'd0, 32'h44);
      end
    join

    // Asynchronous reset in the middle of a write kills the strobe at once.
    next_cycle(t0);
    push_wr(0, 32'h600, 8'h11, t0 + 1);
    push_wr(0, 32'h601, 8'h22, t0 + 2);
    we_v[0][0]    = 1'b1;
    addr_v[0][0]  = 32'h600;
    len_v[0][0]   = 2'd3;
    wdata_v[0][0] = 32'h44332211;
    req_v[0][0]   = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("we_before_rst", 64'(mem_we_v[0]), 64'(1));
    rst_n = 1'b0;
    #1;
    check("we_async_rst",  64'(mem_we_v[0]), 64'(0));
    check("a_async_rst",   64'(mem_a_v[0]),  64'(0));
    req_v[0][0] = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("idle_after_rst_done", 64'(done_v[0]),  64'(0));
    check("idle_after_rst_a",    64'(mem_a_v[0]), 64'(0));
    check("ram_byte2_untouched", 64'(ram[0][12'h602]), 64'(0));
    check("ram_above_len",       64'(ram[0][12'h104]), 64'(0));

    check("wr_queue_left",   64'(exp_wr_q.size()),   64'(0));
    check("done_queue_left", 64'(exp_done_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
